// File: rtl/bus_write_bank_if.sv
// Bus-side signal bundle for bus_write_bank: write/increment controls in, register
// contents and data-memory write port out.
interface bus_write_bank_if #(
  parameter int NARROW_W = 8,
  parameter int WIDE_W   = 16
);
  logic [WIDE_W-1:0]   bus_in;
  logic [3:0]          write_en;
  logic [3:0]          inc_en;
  logic                alu_load;
  logic [WIDE_W-1:0]   alu_in;
  logic                clr_ac;

  logic [NARROW_W-1:0] pc, dr, r, r1, r2, ri, rj, rk, r3, ar;
  logic [WIDE_W-1:0]   ac, tr;
  logic                dm_we;
  logic [NARROW_W-1:0] dm_wdata;
  logic                z_flag;

  modport master (
    output bus_in, write_en, inc_en, alu_load, alu_in, clr_ac,
    input  pc, dr, r, r1, r2, ri, rj, rk, r3, ar, ac, tr, dm_we, dm_wdata, z_flag
  );

  modport slave (
    input  bus_in, write_en, inc_en, alu_load, alu_in, clr_ac,
    output pc, dr, r, r1, r2, ri, rj, rk, r3, ar, ac, tr, dm_we, dm_wdata, z_flag
  );
endinterface

// File: rtl/bus_write_bank.sv
// Destination side of the shared datapath bus: latches bus_in into the selected
// register, applies increment / ALU-load / clear, and strobes data-memory writes.
module bus_write_bank #(
  parameter int NARROW_W = 8,
  parameter int WIDE_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  bus_write_bank_if.slave  bus
);
  localparam logic [3:0] SEL_DM = 4'd1;
  localparam logic [3:0] SEL_PC = 4'd2;
  localparam logic [3:0] SEL_DR = 4'd3;
  localparam logic [3:0] SEL_R  = 4'd4;
  localparam logic [3:0] SEL_AC = 4'd5;
  localparam logic [3:0] SEL_TR = 4'd6;
  localparam logic [3:0] SEL_R1 = 4'd7;
  localparam logic [3:0] SEL_R2 = 4'd8;
  localparam logic [3:0] SEL_RI = 4'd9;
  localparam logic [3:0] SEL_RJ = 4'd10;
  localparam logic [3:0] SEL_RK = 4'd11;
  localparam logic [3:0] SEL_R3 = 4'd12;
  localparam logic [3:0] SEL_AR = 4'd13;

  localparam logic [NARROW_W-1:0] N_ONE = NARROW_W'(1);
  localparam logic [WIDE_W-1:0]   W_ONE = WIDE_W'(1);

  logic [NARROW_W-1:0] pc, dr, r, r1, r2, ri, rj, rk, r3, ar, dm_wdata;
  logic [WIDE_W-1:0]   ac, tr;
  logic                dm_we;

  // Bus write wins over increment on the same register; the increment is dropped.
  function automatic logic [NARROW_W-1:0] next_narrow(
    input logic [NARROW_W-1:0] cur,
    input logic [3:0]          code,
    input logic                incable,
    input logic [3:0]          we,
    input logic [3:0]          inc,
    input logic [NARROW_W-1:0] din
  );
    if (we == code)
      return din;
    else if (incable && inc == code)
      return cur + N_ONE;
    else
      return cur;
  endfunction

  logic [NARROW_W-1:0] bus_lo;
  assign bus_lo = bus.bus_in[NARROW_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= '0;
      dr       <= '0;
      r        <= '0;
      r1       <= '0;
      r2       <= '0;
      ri       <= '0;
      rj       <= '0;
      rk       <= '0;
      r3       <= '0;
      ar       <= '0;
      ac       <= '0;
      tr       <= '0;
      dm_we    <= 1'b0;
      dm_wdata <= '0;
    end else begin
      pc <= next_narrow(pc, SEL_PC, 1'b1, bus.write_en, bus.inc_en, bus_lo);
      dr <= next_narrow(dr, SEL_DR, 1'b0, bus.write_en, bus.inc_en, bus_lo);
      r  <= next_narrow(r,  SEL_R,  1'b0, bus.write_en, bus.inc_en, bus_lo);
      r1 <= next_narrow(r1, SEL_R1, 1'b0, bus.write_en, bus.inc_en, bus_lo);
      r2 <= next_narrow(r2, SEL_R2, 1'b0, bus.write_en, bus.inc_en, bus_lo);
      ri <= next_narrow(ri, SEL_RI, 1'b1, bus.write_en, bus.inc_en, bus_lo);
      rj <= next_narrow(rj, SEL_RJ, 1'b1, bus.write_en, bus.inc_en, bus_lo);
      rk <= next_narrow(rk, SEL_RK, 1'b1, bus.write_en, bus.inc_en, bus_lo);
      r3 <= next_narrow(r3, SEL_R3, 1'b0, bus.write_en, bus.inc_en, bus_lo);
      ar <= next_narrow(ar, SEL_AR, 1'b0, bus.write_en, bus.inc_en, bus_lo);

      // ac priority: clear, then ALU result, then bus, then increment.
      if (bus.clr_ac)
        ac <= '0;
      else if (bus.alu_load)
        ac <= bus.alu_in;
      else if (bus.write_en == SEL_AC)
        ac <= bus.bus_in;
      else if (bus.inc_en == SEL_AC)
        ac <= ac + W_ONE;

      if (bus.write_en == SEL_TR)
        tr <= bus.bus_in;

      dm_we <= (bus.write_en == SEL_DM);
      if (bus.write_en == SEL_DM)
        dm_wdata <= bus_lo;
    end
  end

  assign bus.pc       = pc;
  assign bus.dr       = dr;
  assign bus.r        = r;
  assign bus.r1       = r1;
  assign bus.r2       = r2;
  assign bus.ri       = ri;
  assign bus.rj       = rj;
  assign bus.rk       = rk;
  assign bus.r3       = r3;
  assign bus.ar       = ar;
  assign bus.ac       = ac;
  assign bus.tr       = tr;
  assign bus.dm_we    = dm_we;
  assign bus.dm_wdata = dm_wdata;
  assign bus.z_flag   = (ac == '0);
endmodule
